// File: rtl/pipeline_hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, redirect, I/D-cache miss and halt.
// Optional stall-cycle counter output enabled by defining HAZARD_STALL_CNT_EN.

package cpu_types_pkg;
    localparam int unsigned WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

module pipeline_hazard_unit
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  word_t dec_instruction,
    input  word_t exec_instruction,
    input  logic  exec_MemRead,
    input  logic  exec_redirect,
    input  logic  mem_dREN,
    input  logic  mem_dWEN,
    input  logic  dhit,
    input  logic  ihit,
    input  logic  wb_halt,
    output logic  pc_en,
    output logic  ifid_en,
    output logic  idex_en,
    output logic  exmem_en,
    output logic  memwb_en,
    output logic  ifid_flush,
    output logic  idex_flush,
    output logic  halted
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 6;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LU_STALL,
        ST_DWAIT,
        ST_HALT
    } state_t;

    state_t state, state_nxt;

    logic [OP_W-1:0]  dec_op;
    logic [REG_W-1:0] dec_rs, dec_rt, exec_rt;
    logic             dec_uses_rt;
    logic             loaduse;
    logic             dwait;

    assign dec_op  = dec_instruction[31:26];
    assign dec_rs  = dec_instruction[25:21];
    assign dec_rt  = dec_instruction[20:16];
    assign exec_rt = exec_instruction[20:16];

    // Immediate/function fields and the producer's op/rs play no part in hazard detection
    logic unused_fields;
    assign unused_fields = &{1'b0, dec_instruction[15:0], exec_instruction[31:21],
                             exec_instruction[15:0]};

    // R-type, BEQ, BNE, SW and SC read rt as a source operand
    always_comb begin
        case (dec_op)
            6'h00, 6'h04, 6'h05, 6'h2B, 6'h38: dec_uses_rt = 1'b1;
            default:                           dec_uses_rt = 1'b0;
        endcase
    end

    assign loaduse = exec_MemRead && (exec_rt != REG_W'(0)) &&
                     ((exec_rt == dec_rs) || ((exec_rt == dec_rt) && dec_uses_rt));

    assign dwait = (mem_dREN | mem_dWEN) & ~dhit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // Next state and strobes, in hazard priority order
    always_comb begin
        state_nxt  = ST_RUN;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;

        if (RST) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if ((state == ST_HALT) || wb_halt) begin
            state_nxt = ST_HALT;
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            halted    = 1'b1;
        end else if (dwait) begin
            state_nxt = ST_DWAIT;
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
        end else if (exec_redirect) begin
            // Flushing IF/ID and ID/EX also removes any load-use consumer
            pc_en      = ihit;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (loaduse && (state == ST_RUN)) begin
            state_nxt  = ST_LU_STALL;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    localparam int unsigned CNT_W = 32;

    // Saturating count of cycles where fetch is held outside the halted state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles <= CNT_W'(0);
        end else if (!pc_en && (state != ST_HALT) && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed self-checking bench for pipeline_hazard_unit.
// Counter checks are included when HAZARD_STALL_CNT_EN is defined.

module tb_pipeline_hazard_unit;

    logic        CLK;
    logic        RST;
    logic [31:0] dec_instruction;
    logic [31:0] exec_instruction;
    logic        exec_MemRead;
    logic        exec_redirect;
    logic        mem_dREN;
    logic        mem_dWEN;
    logic        dhit;
    logic        ihit;
    logic        wb_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, halted;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] cnt_snap;
`endif

    int total = 0;
    int bad   = 0;

    // {pc, ifid, idex, exmem, memwb enables, ifid_flush, idex_flush, halted}
    logic [7:0] obs;
    assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};

    localparam logic [7:0] V_ALL1   = 8'b11111_00_0;
    localparam logic [7:0] V_FROZEN = 8'b00000_00_0;
    localparam logic [7:0] V_HALT   = 8'b00000_00_1;
    localparam logic [7:0] V_LU     = 8'b00111_01_0;
    localparam logic [7:0] V_REDIR  = 8'b11111_11_0;
    localparam logic [7:0] V_REDIRM = 8'b01111_11_0;
    localparam logic [7:0] V_IMISS  = 8'b01111_10_0;

    pipeline_hazard_unit dut (
        .CLK              (CLK),
        .RST              (RST),
        .dec_instruction  (dec_instruction),
        .exec_instruction (exec_instruction),
        .exec_MemRead     (exec_MemRead),
        .exec_redirect    (exec_redirect),
        .mem_dREN         (mem_dREN),
        .mem_dWEN         (mem_dWEN),
        .dhit             (dhit),
        .ihit             (ihit),
        .wb_halt          (wb_halt),
        .pc_en            (pc_en),
        .ifid_en          (ifid_en),
        .idex_en          (idex_en),
        .exmem_en         (exmem_en),
        .memwb_en         (memwb_en),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .halted           (halted)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt);
        return {op, rs, rt, 16'h0010};
    endfunction

    function automatic logic [31:0] mk_add(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    task automatic idle();
        dec_instruction  = 32'h0;
        exec_instruction = 32'h0;
        exec_MemRead     = 1'b0;
        exec_redirect    = 1'b0;
        mem_dREN         = 1'b0;
        mem_dWEN         = 1'b0;
        dhit             = 1'b0;
        ihit             = 1'b1;
        wb_halt          = 1'b0;
    endtask

    task automatic set_lw_add(input logic [4:0] lw_rt, input logic [4:0] rs, input logic [4:0] rt);
        exec_instruction = mk_i(6'h23, 5'd1, lw_rt);
        exec_MemRead     = 1'b1;
        dec_instruction  = mk_add(rs, rt, 5'd9);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle();
        wb_halt = 1'b1;
        @(negedge CLK); #1;
        total++; if (obs !== V_FROZEN) begin bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, V_FROZEN); end
`ifdef HAZARD_STALL_CNT_EN
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
`endif
        @(negedge CLK);
        RST = 1'b0;
        idle();
        #1;
        total++; if (obs !== V_ALL1) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, V_ALL1); end
    endtask

    task automatic test_load_use();
        @(negedge CLK);
`ifdef HAZARD_STALL_CNT_EN
        cnt_snap = stall_cycles;
`endif
        set_lw_add(5'd5, 5'd5, 5'd2);
        #1;
        total++; if (obs !== V_LU) begin bad++; $display("FAIL lu_rs_c0 got=%b exp=%b", obs, V_LU); end
        @(negedge CLK);
        exec_instruction = 32'h0;
        exec_MemRead     = 1'b0;
        #1;
        total++; if (obs !== V_ALL1) begin bad++; $display("FAIL lu_rs_c1 got=%b exp=%b", obs, V_ALL1); end
`ifdef HAZARD_STALL_CNT_EN
        total++; if (stall_cycles !== cnt_snap + 32'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cycles, cnt_snap + 32'd1); end
`endif
        // rt match on an R-type; hazard held two cycles shows the stall state masks it once
        @(negedge CLK);
        set_lw_add(5'd7, 5'd1, 5'd7);
        #1;
        total++; if (obs !== V_LU) begin bad++; $display("FAIL lu_rt_c0 got=%b exp=%b", obs, V_LU); end
        @(negedge CLK); #1;
        total++; if (obs !== V_ALL1) begin bad++; $display("FAIL lu_mask got=%b exp=%b", obs, V_ALL1); end
        @(negedge CLK); #1;
        total++; if (obs !== V_LU) begin bad++; $display("FAIL lu_rearm got=%b exp=%b", obs, V_LU); end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_no_hazard();
        @(negedge CLK);
        set_lw_add(5'd0, 5'd0, 5'd0);
        #1;
        total++; if (obs !== V_ALL1) begin bad++; $display("FAIL nh_rt0 got=%b exp=%b", obs, V_ALL1); end
        @(negedge CLK);
        exec_instruction = mk_i(6'h23, 5'd1, 5'd5);
        exec_MemRead     = 1'b1;
        dec_instruction  = mk_i(6'h08, 5'd1, 5'd5);
        #1;
        total++; if (obs !== V_ALL1) begin bad++; $display("FAIL nh_addi_rt got=%b exp=%b", obs, V_ALL1); end
        @(negedge CLK);
        set_lw_add(5'd5, 5'd5, 5'd2);
        exec_MemRead = 1'b0;
        #1;
        total++; if (obs !== V_ALL1) begin bad++; $display("FAIL nh_noload got=%b exp=%b", obs, V_ALL1); end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_dmiss();
        @(negedge CLK);
`ifdef HAZARD_STALL_CNT_EN
        cnt_snap = stall_cycles;
`endif
        for (int c = 0; c < 3; c++) begin
            mem_dREN = 1'b1;
            dhit     = 1'b0;
            #1;
            total++; if (obs !== V_FROZEN) begin bad++; $display("FAIL dmiss_c%0d got=%b exp=%b", c, obs, V_FROZEN); end
            @(negedge CLK);
        end
        dhit = 1'b1;
        #1;
        total++; if (obs !== V_ALL1) begin bad++; $display("FAIL dmiss_hit got=%b exp=%b", obs, V_ALL1); end
`ifdef HAZARD_STALL_CNT_EN
        total++; if (stall_cycles !== cnt_snap + 32'd3) begin bad++; $display("FAIL dmiss_cnt got=%0d exp=%0d", stall_cycles, cnt_snap + 32'd3); end
`endif
        @(negedge CLK);
        idle();
        mem_dWEN = 1'b1;
        #1;
        total++; if (obs !== V_FROZEN) begin bad++; $display("FAIL dmiss_store got=%b exp=%b", obs, V_FROZEN); end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_imiss();
        @(negedge CLK);
        ihit = 1'b0;
        #1;
        total++; if (obs !== V_IMISS) begin bad++; $display("FAIL imiss got=%b exp=%b", obs, V_IMISS); end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_redirect();
        @(negedge CLK);
        set_lw_add(5'd5, 5'd5, 5'd2);
        exec_redirect = 1'b1;
        #1;
        total++; if (obs !== V_REDIR) begin bad++; $display("FAIL redir_lu got=%b exp=%b", obs, V_REDIR); end
        // Stall state was not entered, so the same hazard now stalls
        @(negedge CLK);
        exec_redirect = 1'b0;
        #1;
        total++; if (obs !== V_LU) begin bad++; $display("FAIL redir_no_lu_state got=%b exp=%b", obs, V_LU); end
        @(negedge CLK);
        idle();
        exec_redirect = 1'b1;
        ihit          = 1'b0;
        #1;
        total++; if (obs !== V_REDIRM) begin bad++; $display("FAIL redir_imiss got=%b exp=%b", obs, V_REDIRM); end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_dwait_redirect();
        @(negedge CLK);
        mem_dREN      = 1'b1;
        exec_redirect = 1'b1;
        #1;
        total++; if (obs !== V_FROZEN) begin bad++; $display("FAIL dwr_freeze got=%b exp=%b", obs, V_FROZEN); end
        @(negedge CLK);
        dhit = 1'b1;
        #1;
        total++; if (obs !== V_REDIR) begin bad++; $display("FAIL dwr_hit got=%b exp=%b", obs, V_REDIR); end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_halt();
        @(negedge CLK);
`ifdef HAZARD_STALL_CNT_EN
        cnt_snap = stall_cycles;
`endif
        wb_halt = 1'b1;
        #1;
        total++; if (obs !== V_HALT) begin bad++; $display("FAIL halt_c0 got=%b exp=%b", obs, V_HALT); end
        @(negedge CLK);
        wb_halt = 1'b0;
        #1;
        total++; if (obs !== V_HALT) begin bad++; $display("FAIL halt_sticky got=%b exp=%b", obs, V_HALT); end
        @(negedge CLK);
        exec_redirect = 1'b1;
        #1;
        total++; if (obs !== V_HALT) begin bad++; $display("FAIL halt_over_redir got=%b exp=%b", obs, V_HALT); end
`ifdef HAZARD_STALL_CNT_EN
        total++; if (stall_cycles !== cnt_snap + 32'd1) begin bad++; $display("FAIL halt_cnt got=%0d exp=%0d", stall_cycles, cnt_snap + 32'd1); end
`endif
        @(negedge CLK);
        idle();
        RST = 1'b1;
        #1;
        total++; if (obs !== V_FROZEN) begin bad++; $display("FAIL halt_rst got=%b exp=%b", obs, V_FROZEN); end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total++; if (obs !== V_ALL1) begin bad++; $display("FAIL halt_cleared got=%b exp=%b", obs, V_ALL1); end
`ifdef HAZARD_STALL_CNT_EN
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL halt_cnt_rst got=%0d exp=0", stall_cycles); end
`endif
    endtask

    task automatic test_reset_mid_stall();
        // Enter DWAIT, then drop the access: the stored state alone decides nothing here
        @(negedge CLK);
        mem_dREN = 1'b1;
        @(negedge CLK);
        idle();
        #1;
        total++; if (obs !== V_ALL1) begin bad++; $display("FAIL rmd_pre got=%b exp=%b", obs, V_ALL1); end
        #1;
        RST = 1'b1;
        #1;
        total++; if (obs !== V_FROZEN) begin bad++; $display("FAIL rmd_async got=%b exp=%b", obs, V_FROZEN); end
        RST = 1'b0;
        mem_dREN = 1'b1;
        #1;
        total++; if (obs !== V_FROZEN) begin bad++; $display("FAIL rmd_reenter got=%b exp=%b", obs, V_FROZEN); end
        @(negedge CLK);
        dhit = 1'b1;
        #1;
        total++; if (obs !== V_ALL1) begin bad++; $display("FAIL rmd_hit got=%b exp=%b", obs, V_ALL1); end
        // Reset between edges during LU_STALL must return to RUN without a clock
        @(negedge CLK);
        idle();
        set_lw_add(5'd6, 5'd6, 5'd2);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        RST = 1'b0;
        #1;
        total++; if (obs !== V_LU) begin bad++; $display("FAIL rls_abort got=%b exp=%b", obs, V_LU); end
        @(negedge CLK);
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_dmiss();
        test_imiss();
        test_redirect();
        test_dwait_redirect();
        test_halt();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
